// File: rtl/ps2_pkg.sv
// Shared PS/2 scan-code constants, key-code type and parser state encoding
// for the multi-key tracker.
package ps2_pkg;

    localparam logic [7:0] PS2_BREAK      = 8'hF0;
    localparam logic [7:0] PS2_EXT        = 8'hE0;
    localparam logic [7:0] PS2_PAUSE      = 8'hE1;
    localparam int         PS2_PAUSE_SKIP = 7;

    // {extended, scan byte}
    typedef logic [8:0] key_code_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXT_BRK,
        ST_SKIP
    } parser_state_t;

    // 00 and FF are reported by the controller on overrun/parity trouble.
    function automatic logic is_error_byte(input logic [7:0] b);
        return (b == 8'h00) || (b == 8'hFF);
    endfunction

endpackage

// File: rtl/ps2_scan_parser.sv
// Prefix parser: turns the decoded byte stream into complete make/break codes.
// Code outputs are combinational on the completing byte so the table sees them the same cycle.
//
// state      | meaning
// -----------+----------------------------------------------
// ST_IDLE    | no prefix pending
// ST_EXT     | E0 seen, waiting for extended byte or F0
// ST_BRK     | F0 seen, next byte is a normal break
// ST_EXT_BRK | E0 F0 seen, next byte is an extended break
// ST_SKIP    | inside the pause sequence, discarding bytes
module ps2_scan_parser
    import ps2_pkg::*;
(
    input  logic       Clock,
    input  logic       reset,
    input  logic [7:0] byte_data,
    input  logic       byte_valid,
    output logic       code_valid,
    output key_code_t  code,
    output logic       is_break
);

    parser_state_t state_q, state_d;
    logic [2:0]    skip_q, skip_d;

    always_comb begin
        state_d    = state_q;
        skip_d     = skip_q;
        code_valid = 1'b0;
        code       = '0;
        is_break   = 1'b0;
        if (byte_valid) begin
            if (is_error_byte(byte_data)) begin
                state_d = ST_IDLE;
                skip_d  = '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (byte_data == PS2_EXT) begin
                            state_d = ST_EXT;
                        end else if (byte_data == PS2_BREAK) begin
                            state_d = ST_BRK;
                        end else if (byte_data == PS2_PAUSE) begin
                            state_d = ST_SKIP;
                            skip_d  = 3'(PS2_PAUSE_SKIP);
                        end else begin
                            code_valid = 1'b1;
                            code       = {1'b0, byte_data};
                        end
                    end
                    ST_EXT: begin
                        if (byte_data == PS2_BREAK) begin
                            state_d = ST_EXT_BRK;
                        end else if (byte_data != PS2_EXT) begin
                            code_valid = 1'b1;
                            code       = {1'b1, byte_data};
                            state_d    = ST_IDLE;
                        end
                    end
                    ST_BRK: begin
                        code_valid = 1'b1;
                        code       = {1'b0, byte_data};
                        is_break   = 1'b1;
                        state_d    = ST_IDLE;
                    end
                    ST_EXT_BRK: begin
                        code_valid = 1'b1;
                        code       = {1'b1, byte_data};
                        is_break   = 1'b1;
                        state_d    = ST_IDLE;
                    end
                    ST_SKIP: begin
                        skip_d = (skip_q == 3'd0) ? 3'd0 : skip_q - 3'd1;
                        if (skip_q <= 3'd1) begin
                            state_d = ST_IDLE;
                        end
                    end
                    default: state_d = ST_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            skip_q  <= '0;
        end else begin
            state_q <= state_d;
            skip_q  <= skip_d;
        end
    end

endmodule

// File: rtl/ps2_key_tracker.sv
// Held-key table for up to MAX_KEYS simultaneous keys with press/release events.
// Optional stale-key auto-release is compiled in with PS2_KEY_TIMEOUT_EN.
module ps2_key_tracker
    import ps2_pkg::*;
#(
    parameter int MAX_KEYS        = 4,
    parameter int CLOCK_FREQUENCY = 25000000,
    parameter int TIMEOUT_MS      = 1000
) (
    input  logic                    Clock,
    input  logic                    reset,
    input  logic [7:0]              byte_data,
    input  logic                    byte_valid,
    output logic [9*MAX_KEYS-1:0]   held_codes,
    output logic [MAX_KEYS-1:0]     held_valid,
    output logic                    any_held,
    output logic [8:0]              last_key,
    output logic                    key_event,
    output logic [8:0]              key_event_code,
    output logic                    key_event_break,
    output logic                    overflow
);

    localparam int IW = (MAX_KEYS > 1) ? $clog2(MAX_KEYS) : 1;

    if (MAX_KEYS < 1 || MAX_KEYS > 16 || CLOCK_FREQUENCY < 1000 || TIMEOUT_MS < 1) begin : g_bad_param
        $error("ps2_key_tracker: illegal parameter value");
    end

    logic      code_valid;
    key_code_t code;
    logic      is_break;

    ps2_scan_parser u_parser (
        .Clock      (Clock),
        .reset      (reset),
        .byte_data  (byte_data),
        .byte_valid (byte_valid),
        .code_valid (code_valid),
        .code       (code),
        .is_break   (is_break)
    );

    logic [9*MAX_KEYS-1:0] codes_q, codes_d;
    logic [MAX_KEYS-1:0]   valid_q, valid_d;
    logic                  any_q, any_d;
    key_code_t             last_q, last_d;
    logic                  evt_q, evt_d;
    key_code_t             evt_code_q, evt_code_d;
    logic                  evt_brk_q, evt_brk_d;
    logic                  ovf_q, ovf_d;

    logic          hit_any, free_any;
    logic [IW-1:0] hit_idx, free_idx;

`ifdef PS2_KEY_TIMEOUT_EN
    localparam int            TO_CYCLES = CLOCK_FREQUENCY / 1000 * TIMEOUT_MS;
    localparam int            TW        = (TO_CYCLES > 1) ? $clog2(TO_CYCLES) : 1;
    localparam logic [TW-1:0] TO_LAST   = TW'(TO_CYCLES - 1);

    logic [TW-1:0] cnt_q [MAX_KEYS];
    logic [TW-1:0] cnt_d [MAX_KEYS];
    logic          exp_any;
    logic [IW-1:0] exp_idx;
    key_code_t     exp_code;
`endif

    // Descending scan so the lowest matching/free index wins.
    always_comb begin
        hit_any  = 1'b0;
        hit_idx  = '0;
        free_any = 1'b0;
        free_idx = '0;
        for (int i = MAX_KEYS - 1; i >= 0; i--) begin
            if (valid_q[i] && codes_q[9*i +: 9] == code) begin
                hit_any = 1'b1;
                hit_idx = IW'(i);
            end
            if (!valid_q[i]) begin
                free_any = 1'b1;
                free_idx = IW'(i);
            end
        end
    end

    always_comb begin
        codes_d    = codes_q;
        valid_d    = valid_q;
        last_d     = last_q;
        evt_d      = 1'b0;
        evt_code_d = evt_code_q;
        evt_brk_d  = evt_brk_q;
        ovf_d      = 1'b0;
`ifdef PS2_KEY_TIMEOUT_EN
        exp_any  = 1'b0;
        exp_idx  = '0;
        exp_code = '0;
        for (int i = 0; i < MAX_KEYS; i++) begin
            cnt_d[i] = (cnt_q[i] == TO_LAST) ? cnt_q[i] : cnt_q[i] + 1'b1;
        end
`endif
        if (code_valid) begin
            if (!is_break) begin
                if (hit_any) begin
`ifdef PS2_KEY_TIMEOUT_EN
                    cnt_d[hit_idx] = '0;
`endif
                end else if (free_any) begin
                    codes_d[9*int'(free_idx) +: 9] = code;
                    valid_d[free_idx]              = 1'b1;
                    last_d                         = code;
                    evt_d                          = 1'b1;
                    evt_code_d                     = code;
                    evt_brk_d                      = 1'b0;
`ifdef PS2_KEY_TIMEOUT_EN
                    cnt_d[free_idx] = '0;
`endif
                end else begin
                    ovf_d = 1'b1;
                end
            end else if (hit_any) begin
                codes_d[9*int'(hit_idx) +: 9] = '0;
                valid_d[hit_idx]              = 1'b0;
                evt_d                         = 1'b1;
                evt_code_d                    = code;
                evt_brk_d                     = 1'b1;
                if (last_q == code) begin
                    last_d = '0;
                end
            end
        end
`ifdef PS2_KEY_TIMEOUT_EN
        // A slot touched by this cycle's byte is not eligible to expire.
        for (int i = MAX_KEYS - 1; i >= 0; i--) begin
            if (valid_q[i] && cnt_q[i] == TO_LAST &&
                !(code_valid && hit_any && hit_idx == IW'(i))) begin
                exp_any = 1'b1;
                exp_idx = IW'(i);
            end
        end
        if (exp_any && !evt_d) begin
            exp_code                      = codes_q[9*int'(exp_idx) +: 9];
            codes_d[9*int'(exp_idx) +: 9] = '0;
            valid_d[exp_idx]              = 1'b0;
            evt_d                         = 1'b1;
            evt_code_d                    = exp_code;
            evt_brk_d                     = 1'b1;
            if (last_q == exp_code) begin
                last_d = '0;
            end
        end
`endif
        any_d = |valid_d;
    end

    always_ff @(posedge Clock) begin
        if (!reset) begin
            codes_q    <= '0;
            valid_q    <= '0;
            any_q      <= 1'b0;
            last_q     <= '0;
            evt_q      <= 1'b0;
            evt_code_q <= '0;
            evt_brk_q  <= 1'b0;
            ovf_q      <= 1'b0;
`ifdef PS2_KEY_TIMEOUT_EN
            for (int i = 0; i < MAX_KEYS; i++) begin
                cnt_q[i] <= '0;
            end
`endif
        end else begin
            codes_q    <= codes_d;
            valid_q    <= valid_d;
            any_q      <= any_d;
            last_q     <= last_d;
            evt_q      <= evt_d;
            evt_code_q <= evt_code_d;
            evt_brk_q  <= evt_brk_d;
            ovf_q      <= ovf_d;
`ifdef PS2_KEY_TIMEOUT_EN
            for (int i = 0; i < MAX_KEYS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
`endif
        end
    end

    assign held_codes      = codes_q;
    assign held_valid      = valid_q;
    assign any_held        = any_q;
    assign last_key        = last_q;
    assign key_event       = evt_q;
    assign key_event_code  = evt_code_q;
    assign key_event_break = evt_brk_q;
    assign overflow        = ovf_q;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Table-driven bench for ps2_key_tracker: each record is one byte (or a reset)
// with the outputs expected on the following cycle, checked through a scoreboard queue.
module tb_ps2_key_tracker;

    localparam int MK = 4;

    logic          Clock = 1'b0;
    logic          reset = 1'b0;
    logic [7:0]    byte_data = 8'h00;
    logic          byte_valid = 1'b0;
    logic [9*MK-1:0] held_codes;
    logic [MK-1:0] held_valid;
    logic          any_held;
    logic [8:0]    last_key;
    logic          key_event;
    logic [8:0]    key_event_code;
    logic          key_event_break;
    logic          overflow;

    always #5 Clock = ~Clock;

    ps2_key_tracker #(
        .MAX_KEYS        (MK),
        .CLOCK_FREQUENCY (1000000),
        .TIMEOUT_MS      (1)
    ) dut (
        .Clock           (Clock),
        .reset           (reset),
        .byte_data       (byte_data),
        .byte_valid      (byte_valid),
        .held_codes      (held_codes),
        .held_valid      (held_valid),
        .any_held        (any_held),
        .last_key        (last_key),
        .key_event       (key_event),
        .key_event_code  (key_event_code),
        .key_event_break (key_event_break),
        .overflow        (overflow)
    );

    typedef struct {
        logic        rst;
        logic [7:0]  b;
        logic        evt;
        logic [8:0]  code;
        logic        brk;
        logic        ovf;
        logic [8:0]  last;
        logic [3:0]  valid;
        logic [35:0] codes;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   vidx  = 0;

    task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL v%0d %s: got %0h, expected %0h", vidx, name, act, exp);
        end
    endtask

    function automatic logic [35:0] slots(input logic [8:0] s0, input logic [8:0] s1,
                                          input logic [8:0] s2, input logic [8:0] s3);
        return {s3, s2, s1, s0};
    endfunction

    task automatic add_b(input logic [7:0] b, input logic evt, input logic [8:0] code,
                         input logic brk, input logic ovf, input logic [8:0] last,
                         input logic [3:0] valid, input logic [35:0] codes);
        vec_t v;
        v.rst = 1'b0; v.b = b; v.evt = evt; v.code = code; v.brk = brk;
        v.ovf = ovf; v.last = last; v.valid = valid; v.codes = codes;
        vecs.push_back(v);
    endtask

    task automatic add_r();
        add_b(8'h00, 1'b0, 9'h0, 1'b0, 1'b0, 9'h0, 4'b0000, 36'h0);
        vecs[vecs.size()-1].rst = 1'b1;
    endtask

    task automatic check_pop();
        vec_t e;
        if (exp_q.size() == 0) begin
            chk("scoreboard empty", 36'd1, 36'd0);
            return;
        end
        e = exp_q.pop_front();
        chk("key_event",  36'(key_event),  36'(e.evt));
        chk("overflow",   36'(overflow),   36'(e.ovf));
        chk("last_key",   36'(last_key),   36'(e.last));
        chk("held_valid", 36'(held_valid), 36'(e.valid));
        chk("held_codes", held_codes,      e.codes);
        chk("any_held",   36'(any_held),   36'(|e.valid));
        if (e.evt) begin
            chk("key_event_code",  36'(key_event_code),  36'(e.code));
            chk("key_event_break", 36'(key_event_break), 36'(e.brk));
        end
    endtask

    task automatic apply(input vec_t v);
        @(negedge Clock);
        chk("idle key_event", 36'(key_event), 36'd0);
        chk("idle overflow",  36'(overflow),  36'd0);
        if (v.rst) begin
            reset      = 1'b0;
            byte_valid = 1'b0;
        end else begin
            byte_data  = v.b;
            byte_valid = 1'b1;
        end
        exp_q.push_back(v);
        @(negedge Clock);
        reset      = 1'b1;
        byte_valid = 1'b0;
        check_pop();
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge Clock);
        byte_data  = b;
        byte_valid = 1'b1;
        @(negedge Clock);
        byte_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge Clock);
        reset = 1'b0;
        @(negedge Clock);
        reset = 1'b1;
    endtask

`ifdef PS2_KEY_TIMEOUT_EN
    // Counts negedges from the make becoming visible until the release event.
    task automatic measure(input string nm, input int repeat_at, input int exp_cyc);
        int   cyc;
        logic seen;
        do_reset();
        send_byte(8'h29);
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 3000) begin
            @(negedge Clock);
            cyc++;
            byte_valid = 1'b0;
            if (key_event) begin
                seen = 1'b1;
            end else if (cyc == repeat_at) begin
                byte_data  = 8'h29;
                byte_valid = 1'b1;
            end
        end
        chk({nm, " release seen"}, 36'(seen), 36'd1);
        chk({nm, " release cycle"}, 36'(cyc), 36'(exp_cyc));
        chk({nm, " release break"}, 36'(key_event_break), 36'd1);
        chk({nm, " release code"}, 36'(key_event_code), 36'h029);
        chk({nm, " slot freed"}, 36'(held_valid), 36'd0);
        chk({nm, " last_key"}, 36'(last_key), 36'd0);
    endtask
`endif

    initial begin
        // single make / break
        add_r();
        add_b(8'h29, 1, 9'h029, 0, 0, 9'h029, 4'b0001, slots(9'h029, 9'h0, 9'h0, 9'h0));
        add_b(8'hF0, 0, 9'h000, 0, 0, 9'h029, 4'b0001, slots(9'h029, 9'h0, 9'h0, 9'h0));
        add_b(8'h29, 1, 9'h029, 1, 0, 9'h000, 4'b0000, 36'h0);
        // extended key plus normal key
        add_b(8'hE0, 0, 9'h000, 0, 0, 9'h000, 4'b0000, 36'h0);
        add_b(8'h72, 1, 9'h172, 0, 0, 9'h172, 4'b0001, slots(9'h172, 9'h0, 9'h0, 9'h0));
        add_b(8'h29, 1, 9'h029, 0, 0, 9'h029, 4'b0011, slots(9'h172, 9'h029, 9'h0, 9'h0));
        add_b(8'hE0, 0, 9'h000, 0, 0, 9'h029, 4'b0011, slots(9'h172, 9'h029, 9'h0, 9'h0));
        add_b(8'hF0, 0, 9'h000, 0, 0, 9'h029, 4'b0011, slots(9'h172, 9'h029, 9'h0, 9'h0));
        add_b(8'h72, 1, 9'h172, 1, 0, 9'h029, 4'b0010, slots(9'h0, 9'h029, 9'h0, 9'h0));
        // typematic repeat
        add_r();
        add_b(8'h29, 1, 9'h029, 0, 0, 9'h029, 4'b0001, slots(9'h029, 9'h0, 9'h0, 9'h0));
        for (int i = 0; i < 4; i++)
            add_b(8'h29, 0, 9'h000, 0, 0, 9'h029, 4'b0001, slots(9'h029, 9'h0, 9'h0, 9'h0));
        // full table, overflow, refill of the freed middle slot
        add_r();
        add_b(8'h1C, 1, 9'h01C, 0, 0, 9'h01C, 4'b0001, slots(9'h01C, 9'h0, 9'h0, 9'h0));
        add_b(8'h1B, 1, 9'h01B, 0, 0, 9'h01B, 4'b0011, slots(9'h01C, 9'h01B, 9'h0, 9'h0));
        add_b(8'h23, 1, 9'h023, 0, 0, 9'h023, 4'b0111, slots(9'h01C, 9'h01B, 9'h023, 9'h0));
        add_b(8'h2B, 1, 9'h02B, 0, 0, 9'h02B, 4'b1111, slots(9'h01C, 9'h01B, 9'h023, 9'h02B));
        add_b(8'h29, 0, 9'h000, 0, 1, 9'h02B, 4'b1111, slots(9'h01C, 9'h01B, 9'h023, 9'h02B));
        add_b(8'hE0, 0, 9'h000, 0, 0, 9'h02B, 4'b1111, slots(9'h01C, 9'h01B, 9'h023, 9'h02B));
        add_b(8'h5A, 0, 9'h000, 0, 1, 9'h02B, 4'b1111, slots(9'h01C, 9'h01B, 9'h023, 9'h02B));
        add_b(8'hF0, 0, 9'h000, 0, 0, 9'h02B, 4'b1111, slots(9'h01C, 9'h01B, 9'h023, 9'h02B));
        add_b(8'h55, 0, 9'h000, 0, 0, 9'h02B, 4'b1111, slots(9'h01C, 9'h01B, 9'h023, 9'h02B));
        add_b(8'hF0, 0, 9'h000, 0, 0, 9'h02B, 4'b1111, slots(9'h01C, 9'h01B, 9'h023, 9'h02B));
        add_b(8'h1B, 1, 9'h01B, 1, 0, 9'h02B, 4'b1101, slots(9'h01C, 9'h0, 9'h023, 9'h02B));
        add_b(8'h29, 1, 9'h029, 0, 0, 9'h029, 4'b1111, slots(9'h01C, 9'h029, 9'h023, 9'h02B));
        // pause sequence is swallowed
        add_r();
        add_b(8'hE1, 0, 9'h000, 0, 0, 9'h000, 4'b0000, 36'h0);
        add_b(8'h14, 0, 9'h000, 0, 0, 9'h000, 4'b0000, 36'h0);
        add_b(8'h77, 0, 9'h000, 0, 0, 9'h000, 4'b0000, 36'h0);
        add_b(8'hE1, 0, 9'h000, 0, 0, 9'h000, 4'b0000, 36'h0);
        add_b(8'hF0, 0, 9'h000, 0, 0, 9'h000, 4'b0000, 36'h0);
        add_b(8'h14, 0, 9'h000, 0, 0, 9'h000, 4'b0000, 36'h0);
        add_b(8'hF0, 0, 9'h000, 0, 0, 9'h000, 4'b0000, 36'h0);
        add_b(8'h77, 0, 9'h000, 0, 0, 9'h000, 4'b0000, 36'h0);
        add_b(8'h29, 1, 9'h029, 0, 0, 9'h029, 4'b0001, slots(9'h029, 9'h0, 9'h0, 9'h0));
        // error bytes
        add_b(8'h00, 0, 9'h000, 0, 0, 9'h029, 4'b0001, slots(9'h029, 9'h0, 9'h0, 9'h0));
        add_b(8'hE0, 0, 9'h000, 0, 0, 9'h029, 4'b0001, slots(9'h029, 9'h0, 9'h0, 9'h0));
        add_b(8'hFF, 0, 9'h000, 0, 0, 9'h029, 4'b0001, slots(9'h029, 9'h0, 9'h0, 9'h0));
        add_b(8'h72, 1, 9'h072, 0, 0, 9'h072, 4'b0011, slots(9'h029, 9'h072, 9'h0, 9'h0));
        // reset discards a pending E0
        add_b(8'hE0, 0, 9'h000, 0, 0, 9'h072, 4'b0011, slots(9'h029, 9'h072, 9'h0, 9'h0));
        add_r();
        add_b(8'h72, 1, 9'h072, 0, 0, 9'h072, 4'b0001, slots(9'h072, 9'h0, 9'h0, 9'h0));
        // repeated E0, then release of non-last and last key
        add_b(8'hE0, 0, 9'h000, 0, 0, 9'h072, 4'b0001, slots(9'h072, 9'h0, 9'h0, 9'h0));
        add_b(8'hE0, 0, 9'h000, 0, 0, 9'h072, 4'b0001, slots(9'h072, 9'h0, 9'h0, 9'h0));
        add_b(8'h72, 1, 9'h172, 0, 0, 9'h172, 4'b0011, slots(9'h072, 9'h172, 9'h0, 9'h0));
        add_b(8'hF0, 0, 9'h000, 0, 0, 9'h172, 4'b0011, slots(9'h072, 9'h172, 9'h0, 9'h0));
        add_b(8'h72, 1, 9'h072, 1, 0, 9'h172, 4'b0010, slots(9'h0, 9'h172, 9'h0, 9'h0));
        add_b(8'hE0, 0, 9'h000, 0, 0, 9'h172, 4'b0010, slots(9'h0, 9'h172, 9'h0, 9'h0));
        add_b(8'hF0, 0, 9'h000, 0, 0, 9'h172, 4'b0010, slots(9'h0, 9'h172, 9'h0, 9'h0));
        add_b(8'h72, 1, 9'h172, 1, 0, 9'h000, 4'b0000, 36'h0);

        reset = 1'b0;
        repeat (2) @(negedge Clock);
        reset = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            vidx = i;
            apply(vecs[i]);
        end
        vidx = vecs.size();
        chk("scoreboard drained", 36'(exp_q.size()), 36'd0);

`ifdef PS2_KEY_TIMEOUT_EN
        measure("timeout", -1, 1000);
        measure("timeout refresh", 899, 1900);
`else
        begin
            int evts;
            evts = 0;
            do_reset();
            send_byte(8'h29);
            for (int c = 0; c < 1500; c++) begin
                @(negedge Clock);
                if (key_event) evts++;
            end
            chk("no timeout events", 36'(evts), 36'd0);
            chk("still held", 36'(held_valid), 36'd1);
            chk("still last", 36'(last_key), 36'h029);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ps2_key_tracker.md
Name: ps2_key_tracker

Overview:
- Parametrised multi-key successor to the single-key held-data tracker.
- Consumes the decoded PS/2 byte stream (byte plus one-cycle valid strobe) from the PS/2 controller.
- Parses make, break (F0), extended (E0) and pause (E1) sequences.
- Maintains a table of up to MAX_KEYS simultaneously held keys for game logic (jump plus duck, etc.) and emits one-cycle press/release events.

Parameters:
- MAX_KEYS, 4, number of held-key slots (1..16).
- CLOCK_FREQUENCY, 25000000, Clock rate in Hz; used only by the optional timeout.
- TIMEOUT_MS, 1000, stale-key auto-release time in ms; used only with the optional feature.

Ports:
- Clock  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- byte_data  in  8  received scan-code byte.
- byte_valid  in  1  one-cycle strobe qualifying byte_data.
- held_codes  out  9*MAX_KEYS  slot i occupies bits [9i+8:9i]; code = {ext, byte}.
- held_valid  out  MAX_KEYS  slot i occupied.
- any_held  out  1  OR of held_valid.
- last_key  out  9  most recently newly-pressed key that is still held, else 0.
- key_event  out  1  one-cycle strobe on a table change.
- key_event_code  out  9  code for key_event.
- key_event_break  out  1  1 = release, 0 = press; valid with key_event.
- overflow  out  1  one-cycle strobe when a make is dropped because the table is full.

Behaviour:
- Reset is synchronous on Clock, active low. It clears all outputs, all slots and last_key to 0, and returns the parser to IDLE. Reset mid-sequence discards any partial prefix.
- Parser FSM states: IDLE, EXT, BRK, EXT_BRK, SKIP. One transition per byte_valid; the FSM holds otherwise.
  - IDLE: E0 -> EXT; F0 -> BRK; E1 -> SKIP with skip counter = 7; any other byte = make {0, byte}, stay IDLE.
  - EXT: F0 -> EXT_BRK; E0 -> stay EXT; any other byte = make {1, byte} -> IDLE.
  - BRK: byte = break {0, byte} -> IDLE.
  - EXT_BRK: byte = break {1, byte} -> IDLE.
  - SKIP: decrement the counter on each byte; -> IDLE when it reaches 0. Pause produces no event.
  - Byte 00 or FF in any state is a controller error: -> IDLE, no event.
- Latency: a completing byte at cycle t makes table, last_key, key_event and overflow visible at t+1. All outputs are registered.
- Make handling:
  - Code already held (typematic repeat): no table change, no key_event. Refreshes the slot timer when the optional feature is compiled in.
  - Code not held, free slot exists: write the lowest-index free slot, set held_valid, set last_key = code, pulse key_event with break = 0.
  - Code not held, table full: no change, pulse overflow; last_key is unchanged.
- Break handling:
  - Code held: clear that slot and pulse key_event with break = 1 and the code. If last_key equals the code, last_key becomes 0.
  - Code not held: ignored, no event.
- Slots are not compacted. Remaining entries keep their indices.
- Code 0 is never stored. A make with byte 00 is rejected as an error.
- Occupied slots never hold duplicate codes.

Optional Feature:
- Macro: PS2_KEY_TIMEOUT_EN.
- When defined:
  - Each slot has a ceil(log2(CLOCK_FREQUENCY/1000*TIMEOUT_MS))-bit counter, cleared on allocate and on typematic refresh.
  - When the counter reaches its limit, the slot is released exactly as for a break (key_event with break = 1), covering lost F0 bytes.
  - If a timeout and a byte-driven event fall in the same cycle, the byte event is reported. Expiries are serviced lowest index first, one per cycle; the others wait a cycle.
- When undefined: no counters exist and slots clear only by break or reset.

Decomposition:
- Package ps2_pkg:
  - Constants PS2_BREAK = 8'hF0, PS2_EXT = 8'hE0, PS2_PAUSE = 8'hE1, PS2_PAUSE_SKIP = 7.
  - 9-bit key-code typedef.
  - Parser state enum.
- Sub-module ps2_scan_parser: holds the prefix FSM and skip counter. Outputs code_valid, code (9 bits) and is_break to the slot table in the top module.

Test Plan:
- Send 29 -> next cycle: slot0 = 029, last_key = 029, key_event with break = 0. Then send F0 29 -> slot0 cleared, last_key = 000, key_event with break = 1 and code 029.
- Send E0 72, then 29 -> slot0 = 172, slot1 = 029, last_key = 029. Then send E0 F0 72 -> slot0 freed, slot1 kept, last_key stays 029.
- Send 29 five times (typematic) -> exactly one key_event; table unchanged.
- With MAX_KEYS = 4, make 1C 1B 23 2B 29 -> 29 raises overflow, table unchanged. Then F0 1B then 29 -> 29 is placed in slot1.
- Send E1 14 77 E1 F0 14 F0 77 then 29 -> no events during the pause bytes; 29 is held normally. Assert reset after a lone E0 -> the next 72 is stored as 072.
- With PS2_KEY_TIMEOUT_EN, TIMEOUT_MS = 1, CLOCK_FREQUENCY = 1 MHz: hold 29 with no repeat -> release event 1000 cycles after the make. A repeat at cycle 900 delays the release until cycle 1900.
